// File: rtl/trans_table.sv
// Transposition-table front end: hashes a chess position (80-bit Zobrist-style key)
// and reads or writes its 128-bit entry in DDR through a single-beat AXI4 master.
module trans_table #(
  parameter int          EVAL_WIDTH = 22,
  parameter int          TABLE_LOG2 = 20,
  parameter logic [31:0] ADDR_BASE  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  entry_lookup_in,
  input  logic                  entry_store_in,
  input  logic                  hash_only_in,
  input  logic [255:0]          board_in,
  input  logic                  white_to_move_in,
  input  logic [3:0]            castle_mask_in,
  input  logic [3:0]            en_passant_col_in,
  input  logic [1:0]            flag_in,
  input  logic [EVAL_WIDTH-1:0] eval_in,
  input  logic [7:0]            depth_in,
  output logic                  trans_idle_out,
  output logic                  entry_valid_out,
  output logic [EVAL_WIDTH-1:0] eval_out,
  output logic [7:0]            depth_out,
  output logic [1:0]            flag_out,
  output logic                  collision_out,
  output logic [79:0]           hash_out,
  output logic [2:0]            state_dbg_out,
  output logic [31:0]           trans_axi_araddr,
  output logic [7:0]            trans_axi_arlen,
  output logic [2:0]            trans_axi_arsize,
  output logic [1:0]            trans_axi_arburst,
  output logic [3:0]            trans_axi_arcache,
  output logic                  trans_axi_arlock,
  output logic [2:0]            trans_axi_arprot,
  output logic [3:0]            trans_axi_arqos,
  output logic                  trans_axi_arvalid,
  input  logic                  trans_axi_arready,
  input  logic [127:0]          trans_axi_rdata,
  input  logic [1:0]            trans_axi_rresp,
  input  logic                  trans_axi_rlast,
  input  logic                  trans_axi_rvalid,
  output logic                  trans_axi_rready,
  output logic [31:0]           trans_axi_awaddr,
  output logic [7:0]            trans_axi_awlen,
  output logic [2:0]            trans_axi_awsize,
  output logic [1:0]            trans_axi_awburst,
  output logic [3:0]            trans_axi_awcache,
  output logic                  trans_axi_awlock,
  output logic [2:0]            trans_axi_awprot,
  output logic [3:0]            trans_axi_awqos,
  output logic                  trans_axi_awvalid,
  input  logic                  trans_axi_awready,
  output logic [127:0]          trans_axi_wdata,
  output logic [15:0]           trans_axi_wstrb,
  output logic                  trans_axi_wlast,
  output logic                  trans_axi_wvalid,
  input  logic                  trans_axi_wready,
  input  logic [1:0]            trans_axi_bresp,
  input  logic                  trans_axi_bvalid,
  output logic                  trans_axi_bready
);

  typedef enum logic [2:0] {S_IDLE, S_HASH, S_AR, S_R, S_AW_W, S_B} state_t;
  typedef enum logic [1:0] {OP_HASH, OP_LOOKUP, OP_STORE} op_t;

  localparam logic [79:0] KEY_SEED = 80'hA5F1_3C97_0E6B_D248_59C3;

  // Key i is the seed rotated left by i%80, XORed with the low index byte replicated.
  function automatic logic [79:0] zkey(input logic [10:0] idx);
    logic [159:0] dbl;
    logic [6:0]   rot;
    rot = 7'(idx % 11'd80);
    dbl = {KEY_SEED, KEY_SEED} << rot;
    return dbl[159:80] ^ {10{idx[7:0]}};
  endfunction

  state_t                state_q, state_d;
  op_t                   op_q, op_d;
  logic [255:0]          board_q, board_d;
  logic                  white_q, white_d;
  logic [3:0]            castle_q, castle_d;
  logic [3:0]            ep_q, ep_d;
  logic [1:0]            req_flag_q, req_flag_d;
  logic [EVAL_WIDTH-1:0] req_eval_q, req_eval_d;
  logic [7:0]            req_depth_q, req_depth_d;
  logic [79:0]           hash_q, hash_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  hit_q, hit_d;
  logic                  coll_q, coll_d;
  logic [EVAL_WIDTH-1:0] eval_q, eval_d;
  logic [7:0]            depth_q, depth_d;
  logic [1:0]            flag_q, flag_d;

  logic [79:0]  hash_calc;
  logic [127:0] entry_word;
  logic [31:0]  table_addr;
  logic         hash_match;
  logic         unused_inputs;

  always_comb begin
    hash_calc = '0;
    for (int s = 0; s < 64; s++) begin
      if (board_q[s*4 +: 4] != 4'd0)
        hash_calc = hash_calc ^ zkey(11'(s * 16) + 11'(board_q[s*4 +: 4]));
    end
    if (white_q) hash_calc = hash_calc ^ zkey(11'd1024);
    for (int b = 0; b < 4; b++) begin
      if (castle_q[b]) hash_calc = hash_calc ^ zkey(11'(1025 + b));
    end
    if (ep_q != 4'd0) hash_calc = hash_calc ^ zkey(11'd1029 + 11'(ep_q));
  end

  always_comb begin
    entry_word = '0;
    entry_word[79:0] = hash_q;
    entry_word[80 +: EVAL_WIDTH] = req_eval_q;
    entry_word[80 + EVAL_WIDTH +: 8] = req_depth_q;
    entry_word[88 + EVAL_WIDTH +: 2] = req_flag_q;
    entry_word[127] = 1'b1;
  end

  assign table_addr = ADDR_BASE + (32'(hash_q[TABLE_LOG2-1:0]) << 4);
  assign hash_match = (trans_axi_rdata[79:0] == hash_q);

  // Handshakes: a valid is held with stable payload until its ready is seen on the same
  // clock edge; the beat transfers on that edge. rready/bready are high only while the
  // matching request has already been accepted.
  always_comb begin
    state_d           = state_q;
    op_d              = op_q;
    board_d           = board_q;
    white_d           = white_q;
    castle_d          = castle_q;
    ep_d              = ep_q;
    req_flag_d        = req_flag_q;
    req_eval_d        = req_eval_q;
    req_depth_d       = req_depth_q;
    hash_d            = hash_q;
    aw_done_d         = aw_done_q;
    w_done_d          = w_done_q;
    hit_d             = hit_q;
    coll_d            = coll_q;
    eval_d            = eval_q;
    depth_d           = depth_q;
    flag_d            = flag_q;
    trans_axi_arvalid = 1'b0;
    trans_axi_rready  = 1'b0;
    trans_axi_awvalid = 1'b0;
    trans_axi_wvalid  = 1'b0;
    trans_axi_bready  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (entry_lookup_in || entry_store_in || hash_only_in) begin
          board_d     = board_in;
          white_d     = white_to_move_in;
          castle_d    = castle_mask_in;
          ep_d        = en_passant_col_in;
          req_flag_d  = flag_in;
          req_eval_d  = eval_in;
          req_depth_d = depth_in;
          state_d     = S_HASH;
          if (entry_lookup_in) begin
            op_d    = OP_LOOKUP;
            hit_d   = 1'b0;
            coll_d  = 1'b0;
            eval_d  = '0;
            depth_d = '0;
            flag_d  = '0;
          end else if (entry_store_in) begin
            op_d = OP_STORE;
          end else begin
            op_d = OP_HASH;
          end
        end
      end
      S_HASH: begin
        hash_d = hash_calc;
        case (op_q)
          OP_LOOKUP: state_d = S_AR;
          OP_STORE: begin
            state_d   = S_AW_W;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end
          default:   state_d = S_IDLE;
        endcase
      end
      S_AR: begin
        trans_axi_arvalid = 1'b1;
        if (trans_axi_arready) state_d = S_R;
      end
      S_R: begin
        trans_axi_rready = 1'b1;
        if (trans_axi_rvalid) begin
          hit_d   = trans_axi_rdata[127] && hash_match;
          coll_d  = trans_axi_rdata[127] && !hash_match;
          eval_d  = trans_axi_rdata[80 +: EVAL_WIDTH];
          depth_d = trans_axi_rdata[80 + EVAL_WIDTH +: 8];
          flag_d  = trans_axi_rdata[88 + EVAL_WIDTH +: 2];
          state_d = S_IDLE;
        end
      end
      S_AW_W: begin
        trans_axi_awvalid = !aw_done_q;
        trans_axi_wvalid  = !w_done_q;
        aw_done_d = aw_done_q || trans_axi_awready;
        w_done_d  = w_done_q || trans_axi_wready;
        if (aw_done_d && w_done_d) state_d = S_B;
      end
      S_B: begin
        trans_axi_bready = 1'b1;
        if (trans_axi_bvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= OP_HASH;
      board_q     <= '0;
      white_q     <= 1'b0;
      castle_q    <= '0;
      ep_q        <= '0;
      req_flag_q  <= '0;
      req_eval_q  <= '0;
      req_depth_q <= '0;
      hash_q      <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      hit_q       <= 1'b0;
      coll_q      <= 1'b0;
      eval_q      <= '0;
      depth_q     <= '0;
      flag_q      <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      board_q     <= board_d;
      white_q     <= white_d;
      castle_q    <= castle_d;
      ep_q        <= ep_d;
      req_flag_q  <= req_flag_d;
      req_eval_q  <= req_eval_d;
      req_depth_q <= req_depth_d;
      hash_q      <= hash_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      hit_q       <= hit_d;
      coll_q      <= coll_d;
      eval_q      <= eval_d;
      depth_q     <= depth_d;
      flag_q      <= flag_d;
    end
  end

  assign trans_idle_out  = (state_q == S_IDLE);
  assign entry_valid_out = hit_q;
  assign collision_out   = coll_q;
  assign eval_out        = eval_q;
  assign depth_out       = depth_q;
  assign flag_out        = flag_q;
  assign hash_out        = hash_q;
  assign state_dbg_out   = state_q;

  assign trans_axi_araddr  = table_addr;
  assign trans_axi_arlen   = 8'd0;
  assign trans_axi_arsize  = 3'd4;
  assign trans_axi_arburst = 2'b01;
  assign trans_axi_arcache = 4'b0011;
  assign trans_axi_arlock  = 1'b0;
  assign trans_axi_arprot  = 3'd0;
  assign trans_axi_arqos   = 4'd0;
  assign trans_axi_awaddr  = table_addr;
  assign trans_axi_awlen   = 8'd0;
  assign trans_axi_awsize  = 3'd4;
  assign trans_axi_awburst = 2'b01;
  assign trans_axi_awcache = 4'b0011;
  assign trans_axi_awlock  = 1'b0;
  assign trans_axi_awprot  = 3'd0;
  assign trans_axi_awqos   = 4'd0;
  assign trans_axi_wdata   = entry_word;
  assign trans_axi_wstrb   = 16'hFFFF;
  assign trans_axi_wlast   = 1'b1;

  // Response codes and rlast carry nothing this single-beat master acts on.
  assign unused_inputs = ^{trans_axi_rresp, trans_axi_rlast, trans_axi_bresp, trans_axi_rdata};

endmodule

// File: tb/tb_trans_table.sv
// Bench for trans_table: random positions and requests, a memory/slave model, and a
// scoreboard fed at issue time and drained by an independent output monitor.
module tb_trans_table;
  localparam int EW  = 22;
  localparam int PAD = 128 - 1 - 2 - 8 - EW - 80;
  localparam logic [79:0] SEED = 80'hA5F1_3C97_0E6B_D248_59C3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic lookup_in = 0, store_in = 0, hash_only_in = 0;
  logic [255:0] board_in = '0;
  logic wtm_in = 0;
  logic [3:0] castle_in = '0, ep_in = '0;
  logic [1:0] flag_in = '0;
  logic [EW-1:0] eval_in = '0;
  logic [7:0] depth_in = '0;
  logic idle, hit, coll;
  logic [EW-1:0] eval_out;
  logic [7:0] depth_out;
  logic [1:0] flag_out;
  logic [79:0] hash_out;
  logic [2:0] state_dbg;
  logic [31:0] araddr, awaddr;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, awsize, arprot, awprot;
  logic [1:0] arburst, awburst;
  logic [3:0] arcache, awcache, arqos, awqos;
  logic arlock, awlock, arvalid, awvalid, wvalid, wlast, rready, bready;
  logic [127:0] wdata;
  logic [15:0] wstrb;
  logic arready = 0, awready = 0, wready = 0, rvalid = 0, bvalid = 0;
  logic [127:0] rdata = '0;

  trans_table dut (
    .clk(clk), .reset(reset),
    .entry_lookup_in(lookup_in), .entry_store_in(store_in), .hash_only_in(hash_only_in),
    .board_in(board_in), .white_to_move_in(wtm_in), .castle_mask_in(castle_in),
    .en_passant_col_in(ep_in), .flag_in(flag_in), .eval_in(eval_in), .depth_in(depth_in),
    .trans_idle_out(idle), .entry_valid_out(hit), .eval_out(eval_out), .depth_out(depth_out),
    .flag_out(flag_out), .collision_out(coll), .hash_out(hash_out), .state_dbg_out(state_dbg),
    .trans_axi_araddr(araddr), .trans_axi_arlen(arlen), .trans_axi_arsize(arsize),
    .trans_axi_arburst(arburst), .trans_axi_arcache(arcache), .trans_axi_arlock(arlock),
    .trans_axi_arprot(arprot), .trans_axi_arqos(arqos), .trans_axi_arvalid(arvalid),
    .trans_axi_arready(arready), .trans_axi_rdata(rdata), .trans_axi_rresp(2'b00),
    .trans_axi_rlast(1'b1), .trans_axi_rvalid(rvalid), .trans_axi_rready(rready),
    .trans_axi_awaddr(awaddr), .trans_axi_awlen(awlen), .trans_axi_awsize(awsize),
    .trans_axi_awburst(awburst), .trans_axi_awcache(awcache), .trans_axi_awlock(awlock),
    .trans_axi_awprot(awprot), .trans_axi_awqos(awqos), .trans_axi_awvalid(awvalid),
    .trans_axi_awready(awready), .trans_axi_wdata(wdata), .trans_axi_wstrb(wstrb),
    .trans_axi_wlast(wlast), .trans_axi_wvalid(wvalid), .trans_axi_wready(wready),
    .trans_axi_bresp(2'b00), .trans_axi_bvalid(bvalid), .trans_axi_bready(bready)
  );

  typedef struct {
    logic [255:0] board;
    logic         wtm;
    logic [3:0]   castle;
    logic [3:0]   ep;
  } pos_t;

  typedef struct {
    logic [79:0]   hash;
    logic          hit;
    logic          coll;
    logic [EW-1:0] ev;
    logic [7:0]    dp;
    logic [1:0]    fl;
  } res_t;

  int checks = 0, failures = 0, n_issued = 0, n_done = 0;
  res_t exp_res_q[$];
  logic [31:0] exp_ar_q[$];
  logic [31:0] exp_aw_q[$];
  logic [127:0] exp_w_q[$];
  logic [127:0] model_mem[logic [31:0]];
  pos_t stored_q[$];
  res_t last_res = '{hash: '0, hit: 0, coll: 0, ev: '0, dp: '0, fl: '0};
  logic mon_en = 1'b1, rand_rdy = 1'b0;
  int ar_stall = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: rotate one bit at a time, then XOR in the replicated index byte.
  function automatic logic [79:0] ref_key(input int i);
    logic [79:0] v;
    logic [7:0]  b;
    v = SEED;
    for (int n = 0; n < i % 80; n++) v = {v[78:0], v[79]};
    b = i[7:0];
    return v ^ {10{b}};
  endfunction

  function automatic logic [79:0] ref_hash(input pos_t p);
    logic [79:0] h;
    logic [3:0]  pc;
    h = '0;
    for (int s = 0; s < 64; s++) begin
      pc = p.board[s*4 +: 4];
      if (pc != 0) h = h ^ ref_key(s * 16 + int'(pc));
    end
    if (p.wtm) h = h ^ ref_key(1024);
    for (int b = 0; b < 4; b++) if (p.castle[b]) h = h ^ ref_key(1025 + b);
    if (p.ep != 0) h = h ^ ref_key(1029 + int'(p.ep));
    return h;
  endfunction

  function automatic logic [31:0] ref_addr(input logic [79:0] h);
    return 32'(h % (80'd1 << 20)) * 32'd16;
  endfunction

  function automatic logic [127:0] make_entry(input logic v, input logic [79:0] h,
      input logic [1:0] fl, input logic [7:0] dp, input logic [EW-1:0] ev);
    return {v, {PAD{1'b0}}, fl, dp, ev, h};
  endfunction

  function automatic pos_t rand_pos();
    pos_t p;
    for (int s = 0; s < 64; s++)
      p.board[s*4 +: 4] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
    p.wtm = 1'($urandom_range(0, 1));
    p.castle = 4'($urandom_range(0, 15));
    p.ep = 4'($urandom_range(0, 15));
    return p;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (!idle && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!idle) check("idle_timeout", 128'(idle), 128'd1);
  endtask

  // op: 0 hash-only, 1 lookup, 2 store. Expectations are queued before the request is driven.
  task automatic issue(input int op, input pos_t p, input logic [1:0] fl,
      input logic [7:0] dp, input logic [EW-1:0] ev, input int hold);
    logic [79:0]  h;
    logic [31:0]  a;
    logic [127:0] rd;
    res_t         r;
    wait_idle();
    h = ref_hash(p);
    a = ref_addr(h);
    r = last_res;
    r.hash = h;
    if (op == 1) begin
      rd = model_mem.exists(a) ? model_mem[a] : 128'd0;
      r.hit  = rd[127] && (rd[79:0] == h);
      r.coll = rd[127] && (rd[79:0] != h);
      r.ev   = rd[80 +: EW];
      r.dp   = rd[80 + EW +: 8];
      r.fl   = rd[88 + EW +: 2];
      last_res = r;
      exp_ar_q.push_back(a);
    end else if (op == 2) begin
      model_mem[a] = make_entry(1'b1, h, fl, dp, ev);
      exp_aw_q.push_back(a);
      exp_w_q.push_back(make_entry(1'b1, h, fl, dp, ev));
      stored_q.push_back(p);
    end
    exp_res_q.push_back(r);
    n_issued++;
    board_in = p.board; wtm_in = p.wtm; castle_in = p.castle; ep_in = p.ep;
    flag_in = fl; depth_in = dp; eval_in = ev;
    lookup_in = (op == 1); store_in = (op == 2); hash_only_in = (op == 0);
    repeat (hold) @(negedge clk);
    lookup_in = 0; store_in = 0; hash_only_in = 0;
  endtask

  // Slave model: readies chosen at the falling edge, beats complete on the next rising edge.
  logic ar_fire = 0, rv_fire = 0, aw_fire = 0, w_fire = 0, b_fire = 0;
  logic r_pend = 0, aw_got = 0, w_got = 0;
  logic [31:0] ar_cap = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (ar_fire) begin r_pend = 1; end
      if (rv_fire) rvalid = 0;
      if (aw_fire) aw_got = 1;
      if (w_fire) w_got = 1;
      if (b_fire) bvalid = 0;
      if (ar_stall > 0) begin
        arready = 0;
        if (arvalid) ar_stall--;
      end else begin
        arready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      awready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      wready  = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (r_pend && !rvalid) begin
        rvalid = 1;
        rdata = model_mem.exists(ar_cap) ? model_mem[ar_cap] : 128'd0;
        r_pend = 0;
      end
      if (aw_got && w_got && !bvalid) begin
        bvalid = 1; aw_got = 0; w_got = 0;
      end
      ar_fire = arvalid && arready;
      if (ar_fire) ar_cap = araddr;
      rv_fire = rvalid && rready;
      aw_fire = awvalid && awready;
      w_fire = wvalid && wready;
      b_fire = bvalid && bready;
    end
  end

  // Monitor: samples between the falling and rising edges, when handshake inputs are settled.
  logic prev_idle = 1, prev_arv = 0, prev_arf = 0, prev_awv = 0, prev_awf = 0;
  logic prev_wv = 0, prev_wf = 0, ar_out = 0;
  logic [31:0] prev_araddr = '0, prev_awaddr = '0;
  logic [127:0] prev_wdata = '0;
  initial begin
    res_t r;
    forever begin
      @(negedge clk);
      #2;
      if (reset || !mon_en) begin
        prev_idle = idle; prev_arv = 0; prev_awv = 0; prev_wv = 0; ar_out = 0;
        continue;
      end
      if (prev_arv && !prev_arf) check("ar_hold", {arvalid, araddr}, {1'b1, prev_araddr});
      if (prev_awv && !prev_awf) check("aw_hold", {awvalid, awaddr}, {1'b1, prev_awaddr});
      if (prev_wv && !prev_wf) check("w_hold", {wvalid, wdata}, {1'b1, prev_wdata});
      if (rready) check("r_before_ar", 128'(ar_out), 128'd1);
      if (arvalid && arready) begin
        check("ar_const", {arlen, arsize, arburst, arcache, arlock, arprot, arqos},
              {8'd0, 3'd4, 2'b01, 4'b0011, 1'b0, 3'd0, 4'd0});
        if (exp_ar_q.size() == 0) check("ar_unexpected", 128'd1, 128'd0);
        else check("araddr", araddr, exp_ar_q.pop_front());
        ar_out = 1;
      end
      if (rvalid && rready) ar_out = 0;
      if (awvalid && awready) begin
        check("aw_const", {awlen, awsize, awburst, awcache, awlock, awprot, awqos},
              {8'd0, 3'd4, 2'b01, 4'b0011, 1'b0, 3'd0, 4'd0});
        if (exp_aw_q.size() == 0) check("aw_unexpected", 128'd1, 128'd0);
        else check("awaddr", awaddr, exp_aw_q.pop_front());
      end
      if (wvalid && wready) begin
        check("w_const", {wstrb, wlast}, {16'hFFFF, 1'b1});
        if (exp_w_q.size() == 0) check("w_unexpected", 128'd1, 128'd0);
        else check("wdata", wdata, exp_w_q.pop_front());
      end
      if (idle && !prev_idle) begin
        n_done++;
        if (exp_res_q.size() == 0) check("done_unexpected", 128'd1, 128'd0);
        else begin
          r = exp_res_q.pop_front();
          check("hash_out", hash_out, r.hash);
          check("result", {hit, coll, eval_out, depth_out, flag_out},
                {r.hit, r.coll, r.ev, r.dp, r.fl});
        end
      end
      prev_idle = idle;
      prev_arv = arvalid; prev_arf = arvalid && arready; prev_araddr = araddr;
      prev_awv = awvalid; prev_awf = awvalid && awready; prev_awaddr = awaddr;
      prev_wv = wvalid; prev_wf = wvalid && wready; prev_wdata = wdata;
    end
  end

  initial begin
    pos_t p, empty;
    logic [79:0] h;
    int n;
    empty = '{board: '0, wtm: 0, castle: '0, ep: '0};
    repeat (3) @(negedge clk);
    check("rst_idle", 128'(idle), 128'd1);
    check("rst_outputs", {hit, coll, eval_out, depth_out, flag_out, hash_out}, 128'd0);
    check("rst_valids", {arvalid, awvalid, wvalid}, 128'd0);
    reset = 0;

    issue(0, empty, 2'd0, 8'd0, '0, 1);
    check("hashonly_busy", 128'(idle), 128'd0);
    @(negedge clk);
    check("hashonly_idle_2cyc", 128'(idle), 128'd1);
    check("hash_empty_zero", hash_out, 128'd0);

    p = empty; p.wtm = 1;
    issue(0, p, 2'd0, 8'd0, '0, 2);
    wait_idle();
    check("hash_white_k1024", hash_out, ref_key(1024));

    p = rand_pos();
    issue(2, p, 2'd1, 8'd3, EW'(5), 1);
    issue(1, p, 2'd0, 8'd0, '0, 1);
    wait_idle();
    check("lookup_hit_fields", {hit, coll, eval_out, depth_out, flag_out},
          {1'b1, 1'b0, EW'(5), 8'd3, 2'd1});

    p = rand_pos();
    h = ref_hash(p);
    model_mem[ref_addr(h)] = make_entry(1'b1, h ^ (80'd1 << 70), 2'd2, 8'd9, EW'(77));
    issue(1, p, 2'd0, 8'd0, '0, 1);
    wait_idle();
    check("lookup_collision", {hit, coll}, {1'b0, 1'b1});

    ar_stall = 10;
    issue(1, rand_pos(), 2'd0, 8'd0, '0, 1);

    rand_rdy = 1;
    for (int k = 0; k < 40; k++) begin
      int op, m;
      op = $urandom_range(0, 2);
      p = rand_pos();
      if (op == 1) begin
        m = $urandom_range(0, 3);
        if (m == 0 && stored_q.size() > 0) p = stored_q[$urandom_range(0, stored_q.size() - 1)];
        h = ref_hash(p);
        if (m == 1)
          model_mem[ref_addr(h)] = make_entry(1'b1, h ^ (80'd1 << 50), 2'($urandom),
                                              8'($urandom), EW'($urandom));
        if (m == 3)
          model_mem[ref_addr(h)] = make_entry(1'b0, h, 2'($urandom), 8'($urandom), EW'($urandom));
      end
      issue(op, p, 2'($urandom), 8'($urandom), EW'($urandom), $urandom_range(1, 2));
    end
    wait_idle();
    repeat (3) @(negedge clk);
    check("all_done", 128'(n_done), 128'(n_issued));
    check("queues_empty", 128'(exp_res_q.size() + exp_ar_q.size() + exp_aw_q.size() + exp_w_q.size()),
          128'd0);

    mon_en = 0;
    rand_rdy = 0;
    ar_stall = 30;
    p = rand_pos();
    wait_idle();
    board_in = p.board; lookup_in = 1;
    @(negedge clk);
    lookup_in = 0;
    n = 0;
    while (!arvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("abort_arvalid_seen", 128'(arvalid), 128'd1);
    reset = 1;
    @(negedge clk);
    check("abort_valids_drop", {arvalid, awvalid, wvalid, rready, bready}, 128'd0);
    check("abort_idle", {idle, hash_out}, {1'b1, 80'd0});
    reset = 0;
    ar_stall = 0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
